// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the per-core register file dump reader.
//   NUM_REGS : highest register index dumped (registers 1..NUM_REGS)
//   DATA_W   : register / stream word width
//   ADDR_W   : register file address width
//   HDR_TAG  : tag placed in header word bits [31:24]
//   state_e  : dump FSM state encoding (also exported on the debug port)
//   build_hdr: forms the header word from the core identifier
package regfile_dump_pkg;

    localparam int          NUM_REGS = 20;
    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam logic [7:0]  HDR_TAG  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_e;

    // Header layout: {tag, 21 zero bits, 3-bit core id}
    function automatic logic [DATA_W-1:0] build_hdr(input logic [2:0] core_id);
        return {HDR_TAG, 21'b0, core_id};
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// Per-core debug reader: on start, streams a header word tagged with coreID,
// then registers 1..NUM_REGS in ascending order over a valid/ready stream.
// Each register is read through the register file's spare read port during
// its own LOAD cycle, so the dump is not an atomic snapshot.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle dump request, only honoured in IDLE
//   coreID              core identifier placed in the header word
//   rf_addr / rf_data   register file read port (combinational read data)
//   out_data/out_valid/out_ready/out_last   output word stream
//   busy                high from the cycle after start until done
//   done                one-cycle pulse after the last word is accepted
//   dbg_state           current FSM state, for observation only
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_last
// stay stable until that transfer; out_valid never drops without a transfer
// (except on reset).
module regfile_dump
    import regfile_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        coreID,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rf_addr     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    out_data_d  = build_hdr(coreID);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    idx_d       = FIRST_IDX;
                    state_d     = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                // Read data is sampled at the end of this cycle, so any
                // register write landing before this edge is captured.
                rf_addr     = idx_q;
                out_data_d  = rf_data;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = SEND;
            end
            SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        // done is registered, so raising it on entry makes
                        // it high exactly for the FIN cycle.
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + FIRST_IDX;
                        state_d = LOAD;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= FIRST_IDX;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
